stage_sequencer: RTL and testbench

//  Flight-stage controller for the Saturn V model. Times burn/coast phases of stages 1-3 plus S-IVB relight.

---
 rtl/stage_sequencer.sv | 163 ++++++++++++++++
 tb/tb_stage_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: flight-stage controller for the Saturn V model.
// Times the stage-1/2/3 burns, the inter-stage coasts, the parking-orbit
// coast and the S-IVB relight burn, and raises separation pulses, gimbal
// enable, completion and abort indications for the flight monitor and the
// thrust datapath.
//
// Optional feature macro: ALT_CUTOFF_EN
//   defined   -> burn 3 also ends early once current_altitude >= TARGET_ALT
//                (the burn timer remains a backstop).
//   undefined -> every burn is timer-only and TARGET_ALT has no effect.
module stage_sequencer #(
    parameter int unsigned  N          = 64,
    parameter int unsigned  B1_CYC     = 150,
    parameter int unsigned  B2_CYC     = 360,
    parameter int unsigned  B3_CYC     = 150,
    parameter int unsigned  B4_CYC     = 350,
    parameter int unsigned  COAST_CYC  = 2,
    parameter int unsigned  PARK_CYC   = 100,
    parameter logic [N-1:0] GIMBAL_ALT = N'(64'd30_000_000_000_000),
    parameter logic [N-1:0] TARGET_ALT = N'(64'd188_000_000_000_000)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         launch,
    input  logic         abort,
    input  logic [N-1:0] current_altitude,
    output logic [3:0]   stage_state,
    output logic         engine_on,
    output logic         ignition_end,
    output logic         separate,
    output logic         gimbal_en,
    output logic         done,
    output logic         fault,
    output logic [31:0]  met_cnt
);

    // A zero-length phase would never terminate a down counter, so it runs one cycle.
    localparam logic [31:0] B1_LEN    = (B1_CYC    == 0) ? 32'd1 : 32'(B1_CYC);
    localparam logic [31:0] B2_LEN    = (B2_CYC    == 0) ? 32'd1 : 32'(B2_CYC);
    localparam logic [31:0] B3_LEN    = (B3_CYC    == 0) ? 32'd1 : 32'(B3_CYC);
    localparam logic [31:0] B4_LEN    = (B4_CYC    == 0) ? 32'd1 : 32'(B4_CYC);
    localparam logic [31:0] COAST_LEN = (COAST_CYC == 0) ? 32'd1 : 32'(COAST_CYC);
    localparam logic [31:0] PARK_LEN  = (PARK_CYC  == 0) ? 32'd1 : 32'(PARK_CYC);

`ifdef ALT_CUTOFF_EN
    localparam bit CUTOFF_EN = 1'b1;
`else
    localparam bit CUTOFF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_BURN,
        S_COAST,
        S_PARK,
        S_DONE,
        S_ABORT
    } state_t;

    state_t      state;
    logic [31:0] remaining;
    logic        alt_cutoff;
    logic        in_flight;

    // Burn length for the stage about to ignite.
    function automatic logic [31:0] burn_len(input logic [3:0] k);
        case (k)
            4'd1:    burn_len = B1_LEN;
            4'd2:    burn_len = B2_LEN;
            4'd3:    burn_len = B3_LEN;
            default: burn_len = B4_LEN;
        endcase
    endfunction

    assign alt_cutoff = CUTOFF_EN && (stage_state == 4'd3) &&
                        (current_altitude >= TARGET_ALT);
    assign in_flight  = (state == S_BURN) || (state == S_COAST) || (state == S_PARK);

    // Mission sequencer: phase timing, stage index and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= 32'd0;
            stage_state  <= 4'd0;
            engine_on    <= 1'b0;
            ignition_end <= 1'b0;
            separate     <= 1'b0;
            gimbal_en    <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            met_cnt      <= 32'd0;
        end else begin
            separate <= 1'b0;
            if ((state != S_IDLE) && (current_altitude > GIMBAL_ALT)) begin
                gimbal_en <= 1'b1;
            end
            if (in_flight && (met_cnt != 32'hFFFF_FFFF)) begin
                met_cnt <= met_cnt + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (launch && !abort) begin
                        state        <= S_BURN;
                        stage_state  <= 4'd1;
                        remaining    <= B1_LEN;
                        engine_on    <= 1'b1;
                        ignition_end <= 1'b0;
                        met_cnt      <= 32'd1;
                    end
                end
                S_BURN: begin
                    if (abort) begin
                        state        <= S_ABORT;
                        engine_on    <= 1'b0;
                        ignition_end <= 1'b0;
                        fault        <= 1'b1;
                    end else if ((remaining == 32'd1) || alt_cutoff) begin
                        engine_on    <= 1'b0;
                        ignition_end <= 1'b1;
                        case (stage_state)
                            4'd1, 4'd2: begin
                                state     <= S_COAST;
                                remaining <= COAST_LEN;
                                separate  <= 1'b1;
                            end
                            4'd3: begin
                                state     <= S_PARK;
                                remaining <= PARK_LEN;
                            end
                            default: begin
                                state    <= S_DONE;
                                separate <= 1'b1;
                                done     <= 1'b1;
                            end
                        endcase
                    end else begin
                        remaining <= remaining - 32'd1;
                    end
                end
                S_COAST, S_PARK: begin
                    if (abort) begin
                        state        <= S_ABORT;
                        engine_on    <= 1'b0;
                        ignition_end <= 1'b0;
                        fault        <= 1'b1;
                    end else if (remaining == 32'd1) begin
                        state        <= S_BURN;
                        stage_state  <= stage_state + 4'd1;
                        remaining    <= burn_len(stage_state + 4'd1);
                        engine_on    <= 1'b1;
                        ignition_end <= 1'b0;
                    end else begin
                        remaining <= remaining - 32'd1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: scoreboard bench for stage_sequencer.
// The reference model describes the mission as a timeline indexed by
// mission-elapsed time; each cycle the stimulus side pushes the expected
// outputs and an independent monitor pops and compares them.
module tb_stage_sequencer;

    localparam int N  = 64;
    localparam int B1 = 5;
    localparam int B2 = 4;
    localparam int B3 = 3;
    localparam int B4 = 2;
    localparam int CO = 2;
    localparam int PK = 3;
    localparam logic [63:0] GALT = 64'd30_000_000_000_000;

    // Mission-elapsed time at the end of each phase.
    localparam int E1 = B1;
    localparam int E2 = E1 + CO;
    localparam int E3 = E2 + B2;
    localparam int E4 = E3 + CO;
    localparam int E5 = E4 + B3;
    localparam int E6 = E5 + PK;
    localparam int E7 = E6 + B4;

    logic        clk = 1'b0;
    logic        reset;
    logic        launch;
    logic        abort;
    logic [63:0] current_altitude;
    logic [3:0]  stage_state;
    logic        engine_on;
    logic        ignition_end;
    logic        separate;
    logic        gimbal_en;
    logic        done;
    logic        fault;
    logic [31:0] met_cnt;

    typedef struct packed {
        logic [3:0]  st;
        logic        eng;
        logic        ign;
        logic        sep;
        logic        gim;
        logic        dn;
        logic        flt;
        logic [31:0] met;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: 0 idle, 1 flying, 2 done, 3 aborted.
    int         m_mode;
    int         m_t;
    logic [3:0] m_stage;
    logic       m_gim;
    logic       m_done_entry;

    stage_sequencer #(
        .N(N), .B1_CYC(B1), .B2_CYC(B2), .B3_CYC(B3), .B4_CYC(B4),
        .COAST_CYC(CO), .PARK_CYC(PK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .launch(launch),
        .abort(abort),
        .current_altitude(current_altitude),
        .stage_state(stage_state),
        .engine_on(engine_on),
        .ignition_end(ignition_end),
        .separate(separate),
        .gimbal_en(gimbal_en),
        .done(done),
        .fault(fault),
        .met_cnt(met_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] stage_at(input int t);
        if (t <= E2)      return 4'd1;
        else if (t <= E4) return 4'd2;
        else if (t <= E6) return 4'd3;
        else              return 4'd4;
    endfunction

    function automatic logic burning(input int t);
        return (t <= E1) || (t > E2 && t <= E3) || (t > E4 && t <= E5) || (t > E6 && t <= E7);
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        o.gim = m_gim;
        case (m_mode)
            1: begin
                o.met = 32'(m_t);
                o.st  = stage_at(m_t);
                o.eng = burning(m_t);
                o.ign = !o.eng;
                o.sep = (m_t == E1 + 1) || (m_t == E3 + 1);
            end
            2: begin
                o.met = 32'(m_t);
                o.st  = 4'd4;
                o.ign = 1'b1;
                o.dn  = 1'b1;
                o.sep = m_done_entry;
            end
            3: begin
                o.met = 32'(m_t);
                o.st  = m_stage;
                o.flt = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {stage_state, engine_on, ignition_end, separate, gimbal_en, done, fault, met_cnt};
        return o;
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_t          = 0;
        m_stage      = 4'd0;
        m_gim        = 1'b0;
        m_done_entry = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic a, input logic [63:0] al);
        if (m_mode != 0 && al > GALT) m_gim = 1'b1;
        m_done_entry = 1'b0;
        case (m_mode)
            0: if (l && !a) begin
                m_mode = 1;
                m_t    = 1;
            end
            1: begin
                if (a) begin
                    m_stage = stage_at(m_t);
                    m_t     = m_t + 1;
                    m_mode  = 3;
                end else begin
                    m_t = m_t + 1;
                    if (m_t > E7) begin
                        m_mode       = 2;
                        m_done_entry = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string name, input obs_t expv, input obs_t got);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got st=%0d eng=%0b ign=%0b sep=%0b gim=%0b done=%0b flt=%0b met=%0d, expected st=%0d eng=%0b ign=%0b sep=%0b gim=%0b done=%0b flt=%0b met=%0d",
                     name, got.st, got.eng, got.ign, got.sep, got.gim, got.dn, got.flt, got.met,
                     expv.st, expv.eng, expv.ign, expv.sep, expv.gim, expv.dn, expv.flt, expv.met);
        end
    endtask

    // One clock cycle of stimulus; reset assertion happens mid-cycle so the
    // asynchronous clear can be observed before any clock edge.
    task automatic applyStimulus(input logic l, input logic a, input logic r, input logic [63:0] al);
        @(negedge clk);
        launch           = l;
        abort            = a;
        current_altitude = al;
        if (r) begin
            if (!reset) begin
                reset = 1'b1;
                #1;
                checkOutput("async reset", '0, sample());
            end
            model_reset();
        end else begin
            reset = 1'b0;
            model_step(l, a, al);
        end
        exp_q.push_back(model_out());
    endtask

    function automatic logic [63:0] pick_alt();
        case ($urandom_range(0, 3))
            0:       return 64'd0;
            1:       return GALT;
            2:       return GALT + 64'd1;
            default: return GALT + 64'($urandom);
        endcase
    endfunction

    // Monitor: compares every presented output against the oldest expectation.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput($sformatf("cycle@%0t", $time), e, sample());
            end
        end
    end

    initial begin
        reset            = 1'b0;
        launch           = 1'b0;
        abort            = 1'b0;
        current_altitude = 64'd0;
        model_reset();
        #1 reset = 1'b1;
        repeat (2) applyStimulus(0, 0, 1, 64'd0);

        $display("[TB] nominal mission");
        applyStimulus(1, 0, 0, 64'd0);
        repeat (28) applyStimulus(0, 0, 0, 64'd0);
        applyStimulus(0, 1, 0, 64'd0);
        repeat (2) applyStimulus(0, 0, 0, 64'd0);

        $display("[TB] abort during burn 2");
        applyStimulus(0, 0, 1, 64'd0);
        applyStimulus(1, 0, 0, 64'd0);
        repeat (8) applyStimulus(0, 0, 0, 64'd0);
        applyStimulus(0, 1, 0, 64'd0);
        repeat (3) applyStimulus(0, 0, 0, 64'd0);
        repeat (3) applyStimulus(1, 0, 0, 64'd0);
        repeat (2) applyStimulus(0, 0, 0, 64'd0);

        $display("[TB] gimbal threshold");
        applyStimulus(0, 0, 1, 64'd0);
        applyStimulus(1, 0, 0, 64'd0);
        repeat (2) applyStimulus(0, 0, 0, GALT);
        applyStimulus(0, 0, 0, GALT + 64'd1);
        repeat (4) applyStimulus(0, 0, 0, 64'd0);

        $display("[TB] reset mid-coast and relaunch");
        applyStimulus(0, 0, 1, 64'd0);
        applyStimulus(1, 0, 0, 64'd0);
        repeat (5) applyStimulus(0, 0, 0, 64'd0);
        applyStimulus(0, 0, 1, 64'd0);
        applyStimulus(1, 0, 0, 64'd0);
        repeat (25) applyStimulus(0, 0, 0, 64'd0);

        $display("[TB] launch with abort in idle, launch held");
        applyStimulus(0, 0, 1, 64'd0);
        repeat (3) applyStimulus(1, 1, 0, 64'd0);
        repeat (30) applyStimulus(1, 0, 0, 64'd0);

        $display("[TB] randomized missions");
        applyStimulus(0, 0, 1, 64'd0);
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 199) == 0, pick_alt());
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL queue drained: %0d expectations left, 0 required", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
